// File: rtl/synth_pkg.sv
// synth_pkg
//   Constants shared by the voice generator, MIDI decode and the TDM mixer.
//   - wave_e     : waveform select encoding carried on the 2-bit wavesel bus
//   - SAMPLE_W   : default mixed-sample width (WAVE_W + VOICE_BITS)
//   - SAMPLE_MID : offset-binary midpoint of a mixed sample (silence)
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  localparam int SAMPLE_W = 10;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = SAMPLE_W'(1) << (SAMPLE_W - 1);

endpackage

// File: rtl/wave_shaper.sv
// wave_shaper
//   Combinational per-slot sample generator for the mixer's S2 stage.
//   Picks the unsigned waveform value, converts it to signed (u - midpoint)
//   and zeroes it when the voice is disabled.
//   Ports:
//     addr_i     : phase address of the voice in this slot
//     wavesel_i  : waveform select (wave_e encoding)
//     en_i       : voice is sounding
//     rom_data_i : sine ROM data for addr_i (already aligned by the caller)
//     smp_o      : signed sample, -2^(WAVE_W-1) .. 2^(WAVE_W-1)-1
module wave_shaper
  import synth_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WAVE_W = 8
) (
  input  logic [ADDR_W-1:0]        addr_i,
  input  wave_e                    wavesel_i,
  input  logic                     en_i,
  input  logic [WAVE_W-1:0]        rom_data_i,
  output logic signed [WAVE_W-1:0] smp_o
);

  logic              msb;
  logic [WAVE_W-1:0] ramp2x;
  logic [WAVE_W-1:0] u;

  assign msb    = addr_i[ADDR_W-1];
  // Low address bits doubled: rises over the first half-period, mirrored
  // (bitwise inverted) over the second to form the triangle.
  assign ramp2x = {addr_i[ADDR_W-2 -: WAVE_W-1], 1'b0};

  always_comb begin
    u = '0;
    unique case (wavesel_i)
      WAVE_SINE:   u = rom_data_i;
      WAVE_SQUARE: u = {WAVE_W{msb}};
      WAVE_SAW:    u = addr_i[ADDR_W-1 -: WAVE_W];
      WAVE_TRI:    u = msb ? ~ramp2x : ramp2x;
      default:     u = '0;
    endcase
  end

  // Offset binary to two's complement is just an MSB flip.
  assign smp_o = en_i ? {~u[WAVE_W-1], u[WAVE_W-2:0]} : '0;

endmodule

// File: rtl/tdm_voice_mixer.sv
// tdm_voice_mixer
//   Converts the TDM voice stream into one offset-binary mixed sample per
//   frame. S1 registers the slot and addresses the sine ROM, S2 shapes the
//   sample with the ROM data, S3 feeds the frame accumulator. Only complete,
//   in-order frames (voice 0 .. NUM_VOICES-1) produce an output strobe.
//   Ports:
//     sys_clk, sys_rst        : clock, synchronous active-high reset
//     tdm_voice_num/addr/enabled, wavesel : slot presented this cycle
//     sine_rom_addr/data      : external synchronous sine ROM (1-cycle read)
//     mix_sample              : mixed frame sample, offset binary, held
//     mix_sample_valid        : one-cycle strobe per emitted frame
//     active_voices           : enabled-voice count of the last emitted frame
module tdm_voice_mixer
  import synth_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int WAVE_W     = 8,
  parameter int NUM_VOICES = 4,
  parameter int VOICE_BITS = 2,
  parameter int SAMPLE_W   = WAVE_W + VOICE_BITS
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [VOICE_BITS-1:0] tdm_voice_num,
  input  logic [ADDR_W-1:0]     tdm_voice_addr,
  input  logic                  tdm_voice_enabled,
  input  logic [1:0]            wavesel,
  output logic [ADDR_W-1:0]     sine_rom_addr,
  input  logic [WAVE_W-1:0]     sine_rom_data,
  output logic [SAMPLE_W-1:0]   mix_sample,
  output logic                  mix_sample_valid,
  output logic [VOICE_BITS:0]   active_voices
);

  localparam logic [SAMPLE_W-1:0]   MID        = SAMPLE_W'(1) << (SAMPLE_W - 1);
  localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);

  typedef struct packed {
    logic [VOICE_BITS-1:0] voice;
    logic [ADDR_W-1:0]     addr;
    logic                  en;
    wave_e                 ws;
  } slot_t;

  // vld_pipe_q[0]=S1, [1]=S2, [2]=S3
  logic [2:0]                  vld_pipe_q;
  slot_t                       s1_q, s2_q;
  logic [VOICE_BITS-1:0]       s3_voice_q;
  logic                        s3_en_q;
  logic signed [WAVE_W-1:0]    s3_smp_q;
  logic signed [WAVE_W-1:0]    s2_smp;

  logic signed [SAMPLE_W-1:0]  acc_q, acc_d;
  logic [VOICE_BITS:0]         cnt_q, cnt_d;
  logic                        armed_q, armed_d;
  logic [VOICE_BITS-1:0]       exp_q, exp_d;
  logic [SAMPLE_W-1:0]         mix_q, mix_d;
  logic                        mix_vld_q, mix_vld_d;
  logic [VOICE_BITS:0]         av_q, av_d;

  logic signed [SAMPLE_W-1:0]  s3_ext, sum;
  logic [VOICE_BITS:0]         cnt_sum;
  logic                        first, last, in_seq, emit;
  logic [VOICE_BITS-1:0]       next_voice;

  wave_shaper #(.ADDR_W(ADDR_W), .WAVE_W(WAVE_W)) u_shaper (
    .addr_i     (s2_q.addr),
    .wavesel_i  (s2_q.ws),
    .en_i       (s2_q.en),
    .rom_data_i (sine_rom_data),
    .smp_o      (s2_smp)
  );

  assign s3_ext     = {{(SAMPLE_W-WAVE_W){s3_smp_q[WAVE_W-1]}}, s3_smp_q};
  assign sum        = acc_q + s3_ext;
  assign cnt_sum    = cnt_q + (VOICE_BITS+1)'(s3_en_q);
  assign first      = (s3_voice_q == '0);
  assign last       = (s3_voice_q == LAST_VOICE);
  assign in_seq     = (s3_voice_q == exp_q);
  assign next_voice = last ? '0 : s3_voice_q + VOICE_BITS'(1);
  // in_seq at the last voice implies every earlier slot since voice 0 was
  // in order, so armed_q && in_seq means a complete frame.
  assign emit       = vld_pipe_q[2] && last && armed_q && in_seq;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    exp_d     = exp_q;
    mix_d     = mix_q;
    mix_vld_d = 1'b0;
    av_d      = av_q;
    if (vld_pipe_q[2]) begin
      acc_d = first ? s3_ext : sum;
      cnt_d = first ? (VOICE_BITS+1)'(s3_en_q) : cnt_sum;
      exp_d = next_voice;
      if (first)        armed_d = 1'b1;
      else if (!in_seq) armed_d = 1'b0;
    end
    if (emit) begin
      mix_d     = $unsigned(sum) + MID;
      mix_vld_d = 1'b1;
      av_d      = cnt_sum;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_voice_q <= '0;
      s3_en_q    <= 1'b0;
      s3_smp_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      exp_q      <= '0;
      mix_q      <= MID;
      mix_vld_q  <= 1'b0;
      av_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
      s1_q       <= '{voice: tdm_voice_num, addr: tdm_voice_addr,
                      en: tdm_voice_enabled, ws: wave_e'(wavesel)};
      s2_q       <= s1_q;
      s3_voice_q <= s2_q.voice;
      s3_en_q    <= s2_q.en;
      s3_smp_q   <= s2_smp;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      exp_q      <= exp_d;
      mix_q      <= mix_d;
      mix_vld_q  <= mix_vld_d;
      av_q       <= av_d;
    end
  end

  assign sine_rom_addr    = s1_q.addr;
  assign mix_sample       = mix_q;
  assign mix_sample_valid = mix_vld_q;
  assign active_voices    = av_q;

endmodule

// File: tb/tb_tdm_voice_mixer.sv
module tb_tdm_voice_mixer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] tdm_voice_num;
  logic [7:0] tdm_voice_addr;
  logic       tdm_voice_enabled;
  logic [1:0] wavesel;
  logic [7:0] sine_rom_addr;
  logic [7:0] sine_rom_data = 8'h00;
  logic [9:0] mix_sample;
  logic       mix_sample_valid;
  logic [2:0] active_voices;

  always #5 sys_clk = ~sys_clk;

  tdm_voice_mixer dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .tdm_voice_num     (tdm_voice_num),
    .tdm_voice_addr    (tdm_voice_addr),
    .tdm_voice_enabled (tdm_voice_enabled),
    .wavesel           (wavesel),
    .sine_rom_addr     (sine_rom_addr),
    .sine_rom_data     (sine_rom_data),
    .mix_sample        (mix_sample),
    .mix_sample_valid  (mix_sample_valid),
    .active_voices     (active_voices)
  );

  // Synchronous sine ROM stand-in: arbitrary contents, 0x40 -> 0xC0.
  function automatic int rom_fn(int a);
    if (a == 8'h40) return 8'hC0;
    return (a * 5 + 3) & 255;
  endfunction

  always @(posedge sys_clk) sine_rom_data <= 8'(rom_fn(int'(sine_rom_addr)));

  // ---------------- reference model ----------------
  typedef struct {
    bit       rst;
    bit [1:0] v;
    bit       en;
    bit [1:0] ws;
    bit [7:0] addr;
  } rec_t;

  rec_t hist[$];   // one entry per clock edge: what the DUT sampled
  int checks = 0, errors = 0;
  int exp_mix = 512, exp_av = 0;
  int strobes = 0, last_strobe_edge = -1, prev_strobe_edge = -1;

  function automatic int s_of(rec_t r);
    int u, lo;
    if (!r.en) return 0;
    lo = int'(r.addr) % 128;
    case (r.ws)
      2'd0:    u = rom_fn(int'(r.addr));
      2'd1:    u = (r.addr >= 128) ? 255 : 0;
      2'd2:    u = int'(r.addr);
      default: u = (r.addr >= 128) ? 255 - 2 * lo : 2 * lo;
    endcase
    return u - 128;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one slot for one clock, then check every output against the model.
  // A frame is emitted 3 edges after its last slot was sampled, provided the
  // four slots sampled at edges n-6..n-3 were voices 0,1,2,3 and no reset was
  // sampled anywhere in edges n-6..n.
  task automatic step(bit rst, bit [1:0] v, bit en, bit [1:0] ws, bit [7:0] addr);
    int n, sum, cnt;
    bit ok, ev;
    rec_t r;
    sys_rst = rst; tdm_voice_num = v; tdm_voice_enabled = en;
    wavesel = ws; tdm_voice_addr = addr;
    @(posedge sys_clk);
    r.rst = rst; r.v = v; r.en = en; r.ws = ws; r.addr = addr;
    hist.push_back(r);
    #1;
    n  = hist.size() - 1;
    ev = 1'b0;
    if (hist[n].rst) begin
      exp_mix = 512; exp_av = 0;
    end else if (n >= 6) begin
      ok = 1'b1;
      for (int k = 0; k <= 6; k++) if (hist[n-k].rst) ok = 1'b0;
      for (int k = 0; k < 4; k++) if (int'(hist[n-6+k].v) != k) ok = 1'b0;
      if (ok) begin
        sum = 0; cnt = 0;
        for (int k = 0; k < 4; k++) begin
          sum += s_of(hist[n-6+k]);
          cnt += hist[n-6+k].en ? 1 : 0;
        end
        ev = 1'b1; exp_mix = 512 + sum; exp_av = cnt;
      end
    end
    chk("valid", int'(mix_sample_valid), int'(ev));
    chk("mix_sample", int'(mix_sample), exp_mix);
    chk("active_voices", int'(active_voices), exp_av);
    chk("rom_addr", int'(sine_rom_addr), hist[n].rst ? 0 : int'(hist[n].addr));
    if (mix_sample_valid) begin
      strobes++;
      prev_strobe_edge = last_strobe_edge;
      last_strobe_edge = n;
    end
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    bit [3:0]      en;
    bit [3:0][1:0] ws;    // index = voice
    bit [3:0][7:0] addr;
    int            mix;
    int            av;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int base, e3, nv;
    bit [1:0] v;

    tbl[0] = '{en: 4'b0000, ws: 8'h00, addr: 32'h00000000, mix: 512,  av: 0};
    tbl[1] = '{en: 4'b0001, ws: {2'd0,2'd0,2'd0,2'd1}, addr: 32'h00000080, mix: 639, av: 1};
    tbl[2] = '{en: 4'b0001, ws: {2'd0,2'd0,2'd0,2'd1}, addr: 32'h00000000, mix: 384, av: 1};
    tbl[3] = '{en: 4'b1111, ws: 8'hAA, addr: 32'hFFFFFFFF, mix: 1020, av: 4};
    tbl[4] = '{en: 4'b1111, ws: 8'hAA, addr: 32'h00000000, mix: 0,    av: 4};
    tbl[5] = '{en: 4'b0100, ws: 8'h00, addr: 32'h00400000, mix: 576,  av: 1};
    tbl[6] = '{en: 4'b1111, ws: 8'hFF, addr: 32'h40404040, mix: 512,  av: 4};
    tbl[7] = '{en: 4'b1111, ws: 8'hFF, addr: 32'hC0C0C0C0, mix: 508,  av: 4};
    tbl[8] = '{en: 4'b1111, ws: {2'd3,2'd1,2'd2,2'd0}, addr: 32'h20009040, mix: 400, av: 4};

    // reset
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b0, 2'd0, 8'h00);
    chk("reset_mix", int'(mix_sample), 512);
    chk("reset_valid", int'(mix_sample_valid), 0);

    // all voices disabled, continuous slots: strobe every 4 cycles at 512
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b0, 2'd0, 8'h00);
    chk("idle_period", last_strobe_edge - prev_strobe_edge, 4);

    // table: one frame per vector, then filler slots 0..2 so the strobe
    // (3 edges after the last slot) can be compared against the table
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < 4; i++)
        step(1'b0, 2'(i), tbl[t].en[i], tbl[t].ws[i], tbl[t].addr[i]);
      for (int i = 0; i < 3; i++) step(1'b0, 2'(i), 1'b0, 2'd0, 8'h00);
      chk($sformatf("tbl%0d_valid", t), int'(mix_sample_valid), 1);
      chk($sformatf("tbl%0d_mix", t), int'(mix_sample), tbl[t].mix);
      chk($sformatf("tbl%0d_av", t), int'(active_voices), tbl[t].av);
      step(1'b0, 2'd3, 1'b0, 2'd0, 8'h00);
    end

    // broken slot order 0,1,3,0,1,2,3: only the second frame is emitted
    step(1'b0, 2'd0, 1'b1, 2'd2, 8'hA0);
    step(1'b0, 2'd1, 1'b1, 2'd2, 8'hA0);
    step(1'b0, 2'd3, 1'b1, 2'd2, 8'hA0);
    base = strobes;
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b1, 2'd2, 8'hA0);
    e3 = hist.size() - 1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'(i), 1'b0, 2'd0, 8'h00);
    chk("broken_strobes", strobes - base, 1);
    chk("broken_when", last_strobe_edge, e3 + 3);
    chk("broken_mix", int'(mix_sample), 640);
    step(1'b0, 2'd3, 1'b0, 2'd0, 8'h00);

    // reset while voice 2 is in S3
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b1, 2'd2, 8'hFF);
    step(1'b0, 2'd0, 1'b1, 2'd2, 8'hFF);
    step(1'b1, 2'd1, 1'b1, 2'd2, 8'hFF);
    chk("rst_mid_valid", int'(mix_sample_valid), 0);
    chk("rst_mid_mix", int'(mix_sample), 512);
    chk("rst_mid_av", int'(active_voices), 0);
    base = strobes;
    step(1'b0, 2'd2, 1'b1, 2'd2, 8'hFF);
    step(1'b0, 2'd3, 1'b1, 2'd2, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b1, 2'd1, 8'h80);
    for (int i = 0; i < 3; i++) step(1'b0, 2'(i), 1'b0, 2'd0, 8'h00);
    chk("rst_after_strobes", strobes - base, 1);
    chk("rst_after_mix", int'(mix_sample), 1020);

    // randomized slots, mostly in order, occasional resets
    v = 2'd3;
    for (int i = 0; i < 800; i++) begin
      nv = ($urandom_range(0, 99) < 88) ? int'(v) + 1 : $urandom_range(0, 3);
      v  = 2'(nv);
      step($urandom_range(0, 99) == 0,
           v,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 8'h40 : 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
